// File: rtl/histogram_threshold_sequencer.sv
// rtl/histogram_threshold_sequencer.sv - 256-bin histogram accumulate, derivative scan, star threshold.
// Define HIST_DERIV_SMOOTH_EN for a span-2 derivative (h[i]-h[i-2]) during the scan.
module histogram_threshold_sequencer #(
  parameter int COUNT_W = 16,
  parameter int GUARD   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_pix_valid,
  input  logic [7:0]         i_pix,
  input  logic               i_frame_end,
  output logic               o_pix_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [7:0]         o_threshold,
  output logic [COUNT_W:0]   o_peak_slope,
  output logic               o_overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [COUNT_W-1:0] SAT = '1;

  state_t                    state_q, state_d;
  logic [COUNT_W-1:0]        hist_q [256];
  logic [7:0]                idx_q, idx_d;
  logic signed [COUNT_W:0]   min_q, min_d;
  logic [7:0]                min_idx_q, min_idx_d;
  logic                      overflow_q, overflow_d;
  logic                      done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      ready_q, ready_d;
  logic [7:0]                thr_q, thr_d;
  logic signed [COUNT_W:0]   slope_q, slope_d;

  logic                      wr_en;
  logic [7:0]                wr_addr;
  logic [COUNT_W-1:0]        wr_data;
  logic [COUNT_W-1:0]        pix_cnt;
  logic [COUNT_W-1:0]        cur_cnt;
  logic [COUNT_W-1:0]        prev_cnt;
  logic signed [COUNT_W:0]   deriv;
  logic [8:0]                thr_sum;

  assign pix_cnt = hist_q[i_pix];
  assign cur_cnt = hist_q[idx_q];

  // Both operands are zero-extended so the difference never wraps.
`ifdef HIST_DERIV_SMOOTH_EN
  assign prev_cnt = hist_q[idx_q - 8'd2];
  assign deriv    = (idx_q < 8'd2) ? '0
                  : $signed({1'b0, cur_cnt}) - $signed({1'b0, prev_cnt});
`else
  assign prev_cnt = hist_q[idx_q - 8'd1];
  assign deriv    = (idx_q == 8'd0) ? '0
                  : $signed({1'b0, cur_cnt}) - $signed({1'b0, prev_cnt});
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    min_d      = min_q;
    min_idx_d  = min_idx_q;
    overflow_d = overflow_q;
    thr_d      = thr_q;
    slope_d    = slope_q;
    wr_en      = 1'b0;
    wr_addr    = idx_q;
    wr_data    = '0;
    thr_sum    = '0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_CLEAR;
          idx_d      = 8'd0;
          overflow_d = 1'b0;
        end
      end
      S_CLEAR: begin
        wr_en = 1'b1;
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'd255) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (i_pix_valid) begin
          wr_addr = i_pix;
          if (pix_cnt == SAT) begin
            overflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_data = pix_cnt + 1'b1;
          end
        end
        if (i_frame_end) begin
          state_d   = S_SCAN;
          idx_d     = 8'd0;
          min_d     = '0;
          min_idx_d = 8'd0;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (deriv < min_q) begin
          min_d     = deriv;
          min_idx_d = idx_q;
        end
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'd255) begin
          state_d = S_DONE;
          thr_sum = {1'b0, min_idx_d} + 9'(GUARD);
          thr_d   = thr_sum[8] ? 8'd255 : thr_sum[7:0];
          slope_d = min_d;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d  = (state_d == S_DONE);
  assign busy_d  = (state_d != S_IDLE);
  assign ready_d = (state_d == S_ACCUM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      min_q      <= '0;
      min_idx_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      thr_q      <= '0;
      slope_q    <= '0;
      for (int i = 0; i < 256; i++) hist_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      min_q      <= min_d;
      min_idx_q  <= min_idx_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      thr_q      <= thr_d;
      slope_q    <= slope_d;
      if (wr_en) hist_q[wr_addr] <= wr_data;
    end
  end

  assign o_pix_ready  = ready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_threshold  = thr_q;
  assign o_peak_slope = slope_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_histogram_threshold_sequencer.sv
// tb/tb_histogram_threshold_sequencer.sv - directed self-checking bench for histogram_threshold_sequencer.
module tb_histogram_threshold_sequencer;

  localparam int COUNT_W = 16;

`ifdef HIST_DERIV_SMOOTH_EN
  localparam int B_THR = 14, SAT_THR = 9, CL_THR = 2, CL_SLOPE = 0, P_THR = 34;
`else
  localparam int B_THR = 13, SAT_THR = 8, CL_THR = 255, CL_SLOPE = -10, P_THR = 33;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_start;
  logic             i_pix_valid;
  logic [7:0]       i_pix;
  logic             i_frame_end;
  logic             o_pix_ready;
  logic             o_busy;
  logic             o_done;
  logic [7:0]       o_threshold;
  logic [COUNT_W:0] o_peak_slope;
  logic             o_overflow;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int low_cnt;
  int saw_done;

  histogram_threshold_sequencer #(.COUNT_W(COUNT_W), .GUARD(2)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_pix_valid  (i_pix_valid),
    .i_pix        (i_pix),
    .i_frame_end  (i_frame_end),
    .o_pix_ready  (o_pix_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_threshold  (o_threshold),
    .o_peak_slope (o_peak_slope),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, o_pix_ready, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_thr"}, o_threshold, 0);
    chk({tag, "_slope"}, $signed(o_peak_slope), 0);
    chk({tag, "_ovf"}, o_overflow, 0);
  endtask

  task automatic start_frame(input bit junk, output int low);
    @(negedge i_clk);
    i_start = 1'b1;
    low = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_pix_ready) break;
      low++;
      if (junk) begin
        i_pix_valid = 1'b1;
        i_pix = 8'd50;
      end
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      i_pix_valid = 1'b1;
      i_pix = v;
      @(negedge i_clk);
    end
    i_pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input bit with_pix, input logic [7:0] v, input bit poke, output int l);
    i_frame_end = 1'b1;
    i_pix_valid = with_pix;
    i_pix = v;
    l = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge i_clk);
      l++;
      i_frame_end = 1'b0;
      i_pix_valid = 1'b0;
      i_start = poke && (l == 10);
      if (o_done) break;
    end
    i_start = 1'b0;
  endtask

  task automatic after_done(input string tag);
    @(negedge i_clk);
    chk({tag, "_done_pulse"}, o_done, 0);
    chk({tag, "_idle"}, o_busy, 0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_pix_valid = 1'b0;
    i_pix = 8'd0;
    i_frame_end = 1'b0;
    repeat (2) @(negedge i_clk);
    check_zero("rst");
    i_rst_n = 1'b1;

    // basic frame
    start_frame(1'b0, low_cnt);
    chk("basic_clear_len", low_cnt, 256);
    chk("basic_busy", o_busy, 1);
    send_pix(8'd10, 100);
    send_pix(8'd200, 4);
    finish_frame(1'b0, 8'd0, 1'b0, lat);
    chk("basic_latency", lat, 257);
    chk("basic_thr", o_threshold, B_THR);
    chk("basic_slope", $signed(o_peak_slope), -100);
    chk("basic_ovf", o_overflow, 0);
    after_done("basic");
    chk("basic_hold_thr", o_threshold, B_THR);

    // empty frame
    start_frame(1'b0, low_cnt);
    finish_frame(1'b0, 8'd0, 1'b0, lat);
    chk("empty_latency", lat, 257);
    chk("empty_thr", o_threshold, 2);
    chk("empty_slope", $signed(o_peak_slope), 0);

    // saturation
    start_frame(1'b0, low_cnt);
    send_pix(8'd5, 70000);
    finish_frame(1'b0, 8'd0, 1'b0, lat);
    chk("sat_ovf", o_overflow, 1);
    chk("sat_bin", dut.hist_q[5], 65535);
    chk("sat_slope", $signed(o_peak_slope), -65535);
    chk("sat_thr", o_threshold, SAT_THR);

    // clamp; overflow sticky must clear
    start_frame(1'b0, low_cnt);
    chk("clamp_ovf_cleared", o_overflow, 0);
    send_pix(8'd254, 10);
    finish_frame(1'b0, 8'd0, 1'b0, lat);
    chk("clamp_thr", o_threshold, CL_THR);
    chk("clamp_slope", $signed(o_peak_slope), CL_SLOPE);
    chk("clamp_ovf", o_overflow, 0);

    // protocol: clear-phase pixels, start pokes, frame_end pixel
    start_frame(1'b1, low_cnt);
    chk("proto_clear_len", low_cnt, 256);
    send_pix(8'd30, 1);
    i_start = 1'b1;
    send_pix(8'd30, 1);
    i_start = 1'b0;
    send_pix(8'd30, 1);
    chk("proto_ready_hold", o_pix_ready, 1);
    finish_frame(1'b1, 8'd30, 1'b1, lat);
    chk("proto_latency", lat, 257);
    chk("proto_thr", o_threshold, P_THR);
    chk("proto_slope", $signed(o_peak_slope), -4);
    after_done("proto");

    // reset mid-accumulate
    start_frame(1'b0, low_cnt);
    send_pix(8'd100, 50);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check_zero("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge i_clk);
      if (o_done || o_busy) saw_done++;
    end
    chk("midrst_no_done", saw_done, 0);

    start_frame(1'b0, low_cnt);
    send_pix(8'd10, 100);
    send_pix(8'd200, 4);
    finish_frame(1'b0, 8'd0, 1'b0, lat);
    chk("post_latency", lat, 257);
    chk("post_thr", o_threshold, B_THR);
    chk("post_slope", $signed(o_peak_slope), -100);
    chk("post_ovf", o_overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
